// File: rtl/neuron_mac_accumulator.sv
// Per-neuron pre-activation MAC: accumulates N_INPUTS signed x*w products plus bias,
// then rounds and saturates to the Q-format z_value feeding the activation LUT stage.
module neuron_mac_accumulator #(
   parameter int N_INPUTS = 2,
   parameter int DATA_W   = 8,
   parameter int FRAC_W   = 4,
   parameter int ACC_W    = 20
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic signed [DATA_W-1:0] bias,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] x,
   input  logic signed [DATA_W-1:0] w,
   output logic                     z_valid,
   input  logic                     z_ready,
   output logic signed [DATA_W-1:0] z_value,
   output logic                     busy
);

   localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
   localparam logic [CNT_W-1:0]        CNT_LAST   = CNT_W'(N_INPUTS - 1);
   localparam logic signed [ACC_W-1:0] ROUND_HALF = ACC_W'(2 ** (FRAC_W - 1));
   localparam logic signed [ACC_W-1:0] Z_MAX      = ACC_W'(2 ** (DATA_W - 1) - 1);
   localparam logic signed [ACC_W-1:0] Z_MIN      = ACC_W'(-(2 ** (DATA_W - 1)));

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      FINISH = 2'd2,
      OUTPUT = 2'd3
   } state_t;

   state_t                     state_q, state_d;
   logic signed [ACC_W-1:0]    acc_q, acc_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic signed [DATA_W-1:0]   z_value_q, z_value_d;
   logic                       z_valid_q, z_valid_d;
   logic                       in_ready_q, in_ready_d;
   logic                       busy_q, busy_d;

   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    prod_ext;
   logic signed [ACC_W-1:0]    bias_aligned;
   logic signed [ACC_W-1:0]    rounded;

   // Bias is shifted up so its binary point lines up with the 2*FRAC_W product format.
   assign prod         = x * w;
   assign prod_ext     = {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};
   assign bias_aligned = {{(ACC_W - DATA_W){bias[DATA_W-1]}}, bias} <<< FRAC_W;
   assign rounded      = (acc_q + ROUND_HALF) >>> FRAC_W;

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      z_value_d = z_value_q;
      z_valid_d = z_valid_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               acc_d   = bias_aligned;
               cnt_d   = '0;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            if (in_valid && in_ready_q) begin
               acc_d = acc_q + prod_ext;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_d = FINISH;
               end
            end
         end
         FINISH: begin
            if (rounded > Z_MAX) begin
               z_value_d = Z_MAX[DATA_W-1:0];
            end else if (rounded < Z_MIN) begin
               z_value_d = Z_MIN[DATA_W-1:0];
            end else begin
               z_value_d = rounded[DATA_W-1:0];
            end
            z_valid_d = 1'b1;
            state_d   = OUTPUT;
         end
         OUTPUT: begin
            if (z_ready) begin
               z_valid_d = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      in_ready_d = (state_d == ACCUM);
      busy_d     = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         cnt_q      <= '0;
         z_value_q  <= '0;
         z_valid_q  <= 1'b0;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         z_value_q  <= z_value_d;
         z_valid_q  <= z_valid_d;
         in_ready_q <= in_ready_d;
         busy_q     <= busy_d;
      end
   end

   assign in_ready = in_ready_q;
   assign z_valid  = z_valid_q;
   assign z_value  = z_value_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_neuron_mac_accumulator.sv
// Self-checking bench for neuron_mac_accumulator: directed cases plus random evaluations
// compared against an arithmetic reference model of the round/saturate rule.
module tb_neuron_mac_accumulator;

   logic clk      = 1'b0;
   logic rst      = 1'b0;
   logic start    = 1'b0;
   logic in_valid = 1'b0;
   logic z_ready  = 1'b0;
   logic signed [7:0] bias = '0;
   logic signed [7:0] x    = '0;
   logic signed [7:0] w    = '0;
   logic              in_ready;
   logic              z_valid;
   logic              busy;
   logic signed [7:0] z_value;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   neuron_mac_accumulator #(
      .N_INPUTS(2),
      .DATA_W  (8),
      .FRAC_W  (4),
      .ACC_W   (20)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .bias    (bias),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .x       (x),
      .w       (w),
      .z_valid (z_valid),
      .z_ready (z_ready),
      .z_value (z_value),
      .busy    (busy)
   );

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: exact real-valued sum in units of 2^-8, round half up to 2^-4, clamp to int8.
   function automatic int model_z(input int b, input int x0, input int w0,
                                  input int x1, input int w1);
      int acc;
      int r;
      acc = b * 16 + x0 * w0 + x1 * w1;
      r   = (acc + 8) >>> 4;
      if (r > 127)  r = 127;
      if (r < -128) r = -128;
      return r;
   endfunction

   // One full evaluation; stray start/in_valid pulses are injected where they must be ignored.
   task automatic run_eval(input logic signed [7:0] b,
                           input logic signed [7:0] x0, input logic signed [7:0] w0,
                           input logic signed [7:0] x1, input logic signed [7:0] w1,
                           input int gap, input int hold, input int exp);
      bias  = b;
      start = 1'b1;
      step();
      start = 1'b0;
      bias  = 8'($urandom);
      check("busy_start", busy, 1);
      check("in_ready_accum", in_ready, 1);
      for (int i = 0; i < 2; i++) begin
         for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            x        = 8'($urandom);
            w        = 8'($urandom);
            start    = (g == 0);
            step();
            start = 1'b0;
            check("in_ready_stall", in_ready, 1);
         end
         in_valid = 1'b1;
         x        = (i == 0) ? x0 : x1;
         w        = (i == 0) ? w0 : w1;
         step();
         in_valid = 1'b0;
      end
      check("z_valid_finish", z_valid, 0);
      check("in_ready_finish", in_ready, 0);
      in_valid = 1'b1;
      x        = 8'($urandom);
      w        = 8'($urandom);
      step();
      check("z_valid_rise", z_valid, 1);
      check("z_value", z_value, exp);
      for (int h = 0; h < hold; h++) begin
         start = 1'b1;
         step();
         check("z_valid_hold", z_valid, 1);
         check("z_value_hold", z_value, exp);
         check("in_ready_output", in_ready, 0);
      end
      z_ready = 1'b1;
      start   = 1'b1;
      step();
      start    = 1'b0;
      z_ready  = 1'b0;
      in_valid = 1'b0;
      check("z_valid_fall", z_valid, 0);
      check("busy_idle", busy, 0);
      check("z_value_kept", z_value, exp);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic signed [7:0] rb, rx0, rw0, rx1, rw1;
      #12;
      check("rst_z_valid", z_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_z_value", z_value, 0);
      @(negedge clk);
      rst = 1'b1;
      step();

      $display("[TB] case 1: basic 1.5 result");
      run_eval(-8, 16, 16, 16, 16, 0, 0, 24);

      $display("[TB] case 2: saturation");
      run_eval(0, 127, 127, 127, 127, 0, 0, 127);
      run_eval(-128, -128, 127, -128, 127, 0, 0, -128);

      $display("[TB] case 3: rounding half up");
      run_eval(0, 4, 2, 0, 0, 0, 0, 1);
      run_eval(0, -4, 2, 0, 0, 0, 0, 0);

      $display("[TB] case 4: stalls and held output");
      run_eval(-8, 16, 16, 16, 16, 2, 5, 24);

      $display("[TB] case 5: reset mid-evaluation");
      bias  = -8;
      start = 1'b1;
      step();
      start    = 1'b0;
      in_valid = 1'b1;
      x        = 16;
      w        = 16;
      step();
      in_valid = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_in_ready", in_ready, 0);
      check("midrst_z_valid", z_valid, 0);
      check("midrst_z_value", z_value, 0);
      @(negedge clk);
      rst = 1'b1;
      step();
      run_eval(-8, 16, 16, 16, 16, 0, 0, 24);

      $display("[TB] case 6: random back-to-back evaluations");
      for (int n = 0; n < 24; n++) begin
         rb  = 8'($urandom);
         rx0 = 8'($urandom);
         rw0 = 8'($urandom);
         rx1 = 8'($urandom);
         rw1 = 8'($urandom);
         run_eval(rb, rx0, rw0, rx1, rw1, int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 3)),
                  model_z(int'(rb), int'(rx0), int'(rw0), int'(rx1), int'(rw1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
